// File: rtl/jac18_pkg.sv
// Shared definitions for the Jac1-8 core: opcode map, ALU status bit positions and the
// fetch/execute sequencer state type.
package jac18_pkg;

    localparam int unsigned NUM_OPCODE_BITS = 5;
    localparam int unsigned NUM_STATUS_BITS = 3;

    // Opcode map (instruction[15:11]); 5'h11..5'h1F are reserved and execute as NOP.
    localparam logic [NUM_OPCODE_BITS-1:0] Op_NOP  = 5'h00;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_MOV  = 5'h01;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_ADD  = 5'h02;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_SUB  = 5'h03;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_AND  = 5'h04;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_OR   = 5'h05;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_XOR  = 5'h06;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_NOT  = 5'h07;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_SHL  = 5'h08;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_SHR  = 5'h09;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_LDI  = 5'h0A;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_GOTO = 5'h0B;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_IFZ  = 5'h0C;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_IFNZ = 5'h0D;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_IFEQ = 5'h0E;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_IFST = 5'h0F;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_IFGT = 5'h10;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_RSV_FIRST = 5'h11;
    localparam logic [NUM_OPCODE_BITS-1:0] Op_RSV_LAST  = 5'h1F;

    // ALU status bit positions
    localparam int unsigned ST_Z  = 0;
    localparam int unsigned ST_LT = 1;
    localparam int unsigned ST_GT = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC
    } seq_state_t;

endpackage

// File: rtl/branch_cond.sv
// Skip-condition evaluation for the IFxx family: flags whether the opcode is conditional and
// whether its condition holds for the given ALU status.
module branch_cond
    import jac18_pkg::*;
#(
    parameter int unsigned NumOpCodeBits = NUM_OPCODE_BITS,
    parameter int unsigned NumStatusBits = NUM_STATUS_BITS
) (
    input  logic [NumOpCodeBits-1:0] opcode,
    input  logic [NumStatusBits-1:0] status,
    output logic                     is_cond,
    output logic                     cond_true
);

    // Decode the conditional opcodes and their flag tests
    always_comb begin
        is_cond   = 1'b0;
        cond_true = 1'b0;
        case (opcode)
            NumOpCodeBits'(Op_IFZ): begin
                is_cond   = 1'b1;
                cond_true = status[ST_Z];
            end
            NumOpCodeBits'(Op_IFNZ): begin
                is_cond   = 1'b1;
                cond_true = ~status[ST_Z];
            end
            NumOpCodeBits'(Op_IFEQ): begin
                is_cond   = 1'b1;
                cond_true = status[ST_Z];
            end
            NumOpCodeBits'(Op_IFST): begin
                is_cond   = 1'b1;
                cond_true = status[ST_LT];
            end
            NumOpCodeBits'(Op_IFGT): begin
                is_cond   = 1'b1;
                cond_true = status[ST_GT];
            end
            default: begin
                is_cond   = 1'b0;
                cond_true = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller for the Jac1-8 core. Owns the PC, fetches instruction words over a
// req/ack handshake, holds them for the decoder and strobes exec_en once per instruction.
// Optional feature: define DEBUG_STEP_EN to add a single-step input (step).
module pc_sequencer
    import jac18_pkg::*;
#(
    parameter int unsigned         PC_WIDTH          = 8,
    parameter int unsigned         PROGRAM_DataWidth = 16,
    parameter int unsigned         NumOpCodeBits     = NUM_OPCODE_BITS,
    parameter int unsigned         NumStatusBits     = NUM_STATUS_BITS,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR      = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
`ifdef DEBUG_STEP_EN
    input  logic                         step,
`endif
    output logic                         imem_req,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic                         imem_ack,
    input  logic [PROGRAM_DataWidth-1:0] imem_data,
    output logic [PROGRAM_DataWidth-1:0] instr,
    input  logic [NumOpCodeBits-1:0]     opcode,
    input  logic [PC_WIDTH-1:0]          literal_adr,
    input  logic                         cnt_wr_en,
    input  logic [NumStatusBits-1:0]     status,
    output logic                         exec_en,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         busy
);

    seq_state_t                   state_q, state_d;
    logic [PC_WIDTH-1:0]          pc_q, pc_d;
    logic [PROGRAM_DataWidth-1:0] instr_q, instr_d;
    logic                         is_cond, cond_true;
    logic                         start;

`ifdef DEBUG_STEP_EN
    logic step_q;

    // Edge-detect step so a held-high step still runs only one instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign start = run | (step & ~step_q);
`else
    assign start = run;
`endif

    branch_cond #(
        .NumOpCodeBits (NumOpCodeBits),
        .NumStatusBits (NumStatusBits)
    ) u_branch_cond (
        .opcode    (opcode),
        .status    (status),
        .is_cond   (is_cond),
        .cond_true (cond_true)
    );

    // State, PC and instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state, PC update and instruction capture
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = EXEC;
            end
            EXEC: begin
                // Status is only looked at here; GOTO overrides any skip decision
                if (cnt_wr_en) begin
                    pc_d = literal_adr;
                end else if (is_cond && !cond_true) begin
                    pc_d = pc_q + PC_WIDTH'(2);
                end else begin
                    pc_d = pc_q + PC_WIDTH'(1);
                end
                state_d = run ? FETCH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        imem_req  = (state_q == FETCH);
        imem_addr = (state_q == FETCH) ? pc_q : '0;
        exec_en   = (state_q == EXEC);
        busy      = (state_q != IDLE);
        instr     = instr_q;
        pc        = pc_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: behavioural program memory with programmable ack delay,
// a trivial decoder, and a scoreboard of expected fetch addresses.
module tb_pc_sequencer;
    import jac18_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
`ifdef DEBUG_STEP_EN
    logic        step = 1'b0;
`endif
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic [7:0]  literal_adr;
    logic        cnt_wr_en;
    logic [2:0]  status = 3'b000;
    logic        exec_en;
    logic [7:0]  pc;
    logic        busy;

    logic [15:0] mem [256];
    int          ack_delay = 0;
    logic        ack_force = 1'b0;
    int          wait_cnt;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
`ifdef DEBUG_STEP_EN
        .step        (step),
`endif
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr       (instr),
        .opcode      (opcode),
        .literal_adr (literal_adr),
        .cnt_wr_en   (cnt_wr_en),
        .status      (status),
        .exec_en     (exec_en),
        .pc          (pc),
        .busy        (busy)
    );

    // Memory: ack after ack_delay wait cycles; data is junk until the ack cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign imem_ack  = ack_force | (imem_req & (wait_cnt >= ack_delay));
    assign imem_data = imem_ack ? mem[imem_addr] : 16'hDEAD;

    // Decoder stand-in
    assign opcode      = instr[15:11];
    assign literal_adr = instr[7:0];
    assign cnt_wr_en   = (instr[15:11] == Op_GOTO);

    // Scoreboard: each completed fetch must match the next expected address
    always @(negedge clk) begin
        if (rst_n && imem_req && imem_ack) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL fetch_order: unexpected fetch addr=%h, none expected", imem_addr);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (imem_addr !== e)
                    $display("FAIL fetch_order: addr=%h expected=%h", imem_addr, e);
                else n_pass++;
            end
        end
    end

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [7:0] lit);
        return {op, 3'b000, lit};
    endfunction

    // Run until n exec pulses, dropping run during the last EXEC, then settle in IDLE
    task automatic exec_n(input int n);
        int cnt = 0;
        run = 1'b1;
        for (int c = 0; c < 300 && cnt < n; c++) begin
            @(negedge clk);
            if (exec_en === 1'b1) begin
                cnt++;
                if (cnt == n) run = 1'b0;
            end
        end
        run = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cnt != n || busy !== 1'b0)
            $display("FAIL exec_n: execs=%0d busy=%b expected execs=%0d busy=0", cnt, busy, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({imem_req, exec_en, busy} !== 3'b000 || imem_addr !== 8'h00 || pc !== 8'h00 ||
            instr !== 16'h0000)
            $display("FAIL reset: req=%b exec=%b busy=%b addr=%h pc=%h instr=%h expected all 0",
                     imem_req, exec_en, busy, imem_addr, pc, instr);
        else n_pass++;
    endtask

    task automatic test_nop_stream();
        logic exp_req, exp_exec;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        @(negedge clk);
        run   = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_req  = (k % 3 == 1);
            exp_exec = (k % 3 == 0);
            n_checks++;
            if (imem_req !== exp_req || exec_en !== exp_exec)
                $display("FAIL nop_cycle%0d: req=%b exec=%b expected req=%b exec=%b",
                         k, imem_req, exec_en, exp_req, exp_exec);
            else n_pass++;
            if (exp_req) begin
                n_checks++;
                if (imem_addr !== 8'((k - 1) / 3))
                    $display("FAIL nop_addr%0d: addr=%h expected=%h", k, imem_addr, (k - 1) / 3);
                else n_pass++;
            end
            if (k == 9) run = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (pc !== 8'h03 || busy !== 1'b0)
            $display("FAIL nop_end: pc=%h busy=%b expected pc=03 busy=0", pc, busy);
        else n_pass++;
    endtask

    task automatic test_goto();
        mem[5] = enc(Op_GOTO, 8'h40);
        mem[8'h41] = enc(Op_GOTO, 8'h0A);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h40);
        exec_n(4);
        n_checks++;
        if (pc !== 8'h41) $display("FAIL goto_pc: pc=%h expected=41", pc);
        else n_pass++;
    endtask

    task automatic test_ifz();
        mem[10] = enc(Op_IFZ, 8'h00);
        mem[12] = enc(Op_GOTO, 8'h0A);
        status  = 3'b000;
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h0A);
        exec_n(2);
        n_checks++;
        if (pc !== 8'h0C) $display("FAIL ifz_false: pc=%h expected=0c", pc);
        else n_pass++;
        exp_q.push_back(8'h0C);
        exec_n(1);
        status = 3'b001;
        exp_q.push_back(8'h0A);
        exec_n(1);
        n_checks++;
        if (pc !== 8'h0B) $display("FAIL ifz_true: pc=%h expected=0b", pc);
        else n_pass++;
    endtask

    typedef struct {
        logic [4:0] op;
        logic [2:0] st;
        logic [7:0] nxt;
    } cond_case_t;

    task automatic test_cond_table();
        cond_case_t tbl [8];
        tbl[0] = '{Op_IFNZ, 3'b000, 8'h81};
        tbl[1] = '{Op_IFNZ, 3'b001, 8'h82};
        tbl[2] = '{Op_IFEQ, 3'b001, 8'h81};
        tbl[3] = '{Op_IFST, 3'b010, 8'h81};
        tbl[4] = '{Op_IFST, 3'b100, 8'h82};
        tbl[5] = '{Op_IFGT, 3'b100, 8'h81};
        tbl[6] = '{Op_IFGT, 3'b011, 8'h82};
        tbl[7] = '{Op_RSV_LAST, 3'b000, 8'h81};
        mem[11]    = enc(Op_GOTO, 8'h80);
        mem[8'h81] = enc(Op_GOTO, 8'h80);
        mem[8'h82] = enc(Op_GOTO, 8'h80);
        exp_q.push_back(8'h0B);
        exec_n(1);
        for (int i = 0; i < 8; i++) begin
            mem[8'h80] = enc(tbl[i].op, 8'h00);
            status = tbl[i].st;
            exp_q.push_back(8'h80);
            exec_n(1);
            n_checks++;
            if (pc !== tbl[i].nxt)
                $display("FAIL cond_case%0d: op=%h st=%b pc=%h expected=%h",
                         i, tbl[i].op, tbl[i].st, pc, tbl[i].nxt);
            else n_pass++;
            exp_q.push_back(tbl[i].nxt);
            exec_n(1);
        end
    endtask

    task automatic test_ack_delay();
        int req_cycles = 0;
        int exec_cycles = 0;
        mem[8'h80] = enc(Op_RSV_LAST, 8'h55);
        ack_delay = 3;
        exp_q.push_back(8'h80);
        run = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (imem_req === 1'b1 && imem_addr === 8'h80) req_cycles++;
            if (exec_en === 1'b1) exec_cycles++;
            if (k == 6) run = 1'b0;
        end
        ack_delay = 0;
        n_checks++;
        if (req_cycles != 4) $display("FAIL ack_req_hold: cycles=%0d expected=4", req_cycles);
        else n_pass++;
        n_checks++;
        if (exec_cycles != 1) $display("FAIL ack_exec_pulse: pulses=%0d expected=1", exec_cycles);
        else n_pass++;
        n_checks++;
        if (instr !== 16'hF855 || pc !== 8'h81 || busy !== 1'b0)
            $display("FAIL ack_instr: instr=%h pc=%h busy=%b expected instr=f855 pc=81 busy=0",
                     instr, pc, busy);
        else n_pass++;
    endtask

    task automatic test_wrap();
        mem[8'h81] = enc(Op_GOTO, 8'hFE);
        mem[8'hFE] = enc(Op_IFGT, 8'h00);
        status = 3'b000;
        exp_q.push_back(8'h81);
        exp_q.push_back(8'hFE);
        exec_n(2);
        n_checks++;
        if (pc !== 8'h00) $display("FAIL wrap_skip: pc=%h expected=00", pc);
        else n_pass++;
        mem[0]     = enc(Op_GOTO, 8'hFF);
        mem[8'hFF] = enc(Op_NOP, 8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exec_n(2);
        n_checks++;
        if (pc !== 8'h00) $display("FAIL wrap_nop: pc=%h expected=00", pc);
        else n_pass++;
    endtask

    task automatic test_status_sampling();
        mem[0]     = enc(Op_GOTO, 8'hF0);
        mem[8'hF0] = enc(Op_IFZ, 8'h00);
        exp_q.push_back(8'h00);
        exec_n(1);
        exp_q.push_back(8'hF0);
        status = 3'b001;
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        status = 3'b000;
        run = 1'b0;
        @(negedge clk);
        n_checks++;
        if (exec_en !== 1'b1) $display("FAIL stat_exec: exec_en=%b expected=1", exec_en);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (pc !== 8'hF2 || busy !== 1'b0)
            $display("FAIL stat_sample: pc=%h busy=%b expected pc=f2 busy=0", pc, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        ack_delay = 5;
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'hF2)
            $display("FAIL rst_pre: req=%b addr=%h expected req=1 addr=f2", imem_req, imem_addr);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || busy !== 1'b0 || pc !== 8'h00 || instr !== 16'h0000 ||
            imem_addr !== 8'h00)
            $display("FAIL rst_async: req=%b busy=%b pc=%h instr=%h addr=%h expected zeros",
                     imem_req, busy, pc, instr, imem_addr);
        else n_pass++;
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ack_force = 1'b1;
        repeat (3) @(negedge clk);
        ack_force = 1'b0;
        ack_delay = 0;
        n_checks++;
        if (busy !== 1'b0 || instr !== 16'h0000 || pc !== 8'h00)
            $display("FAIL late_ack: busy=%b instr=%h pc=%h expected 0/0000/00", busy, instr, pc);
        else n_pass++;
    endtask

    task automatic test_run_drop();
        mem[0] = enc(Op_GOTO, 8'hFF);
        exp_q.push_back(8'h00);
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        n_checks++;
        if (exec_en !== 1'b1 || busy !== 1'b1)
            $display("FAIL drop_exec: exec=%b busy=%b expected 1/1", exec_en, busy);
        else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || imem_req !== 1'b0 || pc !== 8'hFF)
            $display("FAIL drop_idle: busy=%b req=%b pc=%h expected 0/0/ff", busy, imem_req, pc);
        else n_pass++;
    endtask

`ifdef DEBUG_STEP_EN
    task automatic test_step();
        int execs = 0;
        exp_q.push_back(8'hFF);
        step = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (exec_en === 1'b1) execs++;
        end
        step = 1'b0;
        n_checks++;
        if (execs != 1 || busy !== 1'b0 || pc !== 8'h00)
            $display("FAIL step: execs=%0d busy=%b pc=%h expected 1/0/00", execs, busy, pc);
        else n_pass++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        test_reset();
        test_nop_stream();
        test_goto();
        test_ifz();
        test_cond_table();
        test_ack_delay();
        test_wrap();
        test_status_sampling();
        test_reset_mid_fetch();
        test_run_drop();
`ifdef DEBUG_STEP_EN
        test_step();
`endif
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL fetch_left: %0d expected fetches missing",
                                        exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
